memory_reader: RTL and testbench

- Read-side controller for the 16x8 dual-read-port register memory.
- On a start pulse, walks the memory two entries per cycle through the two read ports, accumulating the sum of all entries.
- Presents the result with a one-cycle done pulse.
- Sits between the memory and the display/reporting logic.

---
 rtl/memory_pkg.sv | 23 ++
 rtl/memory_reader_pair_accumulator.sv | 72 +++++++
 rtl/memory_reader.sv | 116 +++++++++++
 tb/tb_memory_reader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : memory_pkg
//  Purpose  : Shared geometry constants and reader FSM state type for the
//             16x8 dual-read-port register memory, its reader and the
//             display/reporting logic.
//  Revision : 1.0 - initial release
// ============================================================================
package memory_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int SUM_W  = DATA_W + ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } reader_state_t;

endpackage : memory_pkg
`default_nettype wire

// File: rtl/memory_reader_pair_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : pair_accumulator
//  Purpose  : Running sum of two memory words per enabled cycle, with an
//             optional running unsigned maximum.
//  Options  : MEMORY_READER_MAX_EN adds the o_max_val output and its logic.
//  Revision : 1.0 - initial release
// ============================================================================
module pair_accumulator
    import memory_pkg::*;
#(
    parameter int DATA_W = memory_pkg::DATA_W,
    parameter int SUM_W  = memory_pkg::SUM_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_enable,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [DATA_W-1:0] i_data2,
`ifdef MEMORY_READER_MAX_EN
    output logic [DATA_W-1:0] o_max_val,
`endif
    output logic [SUM_W-1:0]  o_sum
);

    logic [SUM_W-1:0] r_sum;
    logic [SUM_W-1:0] w_pair_sum;

    // Both words are zero-extended before the add so the pair can never wrap.
    always_comb begin
        w_pair_sum = SUM_W'(i_data1) + SUM_W'(i_data2);
    end

    // Accumulator: clear wins over enable so a new scan always starts at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sum <= '0;
        end else if (i_clear) begin
            r_sum <= '0;
        end else if (i_enable) begin
            r_sum <= r_sum + w_pair_sum;
        end
    end

    assign o_sum = r_sum;

`ifdef MEMORY_READER_MAX_EN
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] w_pair_max;

    // Larger of the two words presented this cycle, unsigned.
    always_comb begin
        w_pair_max = (i_data1 > i_data2) ? i_data1 : i_data2;
    end

    // Running maximum, restarted from zero with each accepted scan.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_max <= '0;
        end else if (i_clear) begin
            r_max <= '0;
        end else if (i_enable && (w_pair_max > r_max)) begin
            r_max <= w_pair_max;
        end
    end

    assign o_max_val = r_max;
`endif

endmodule : pair_accumulator
`default_nettype wire

// File: rtl/memory_reader.sv
`default_nettype none
// ============================================================================
//  Module   : memory_reader
//  Purpose  : Scans the dual-read-port memory two words per cycle on a start
//             pulse, accumulates the sum of all words and signals completion
//             with a one-cycle done pulse.
//  Options  : MEMORY_READER_MAX_EN adds the max_val output (running maximum).
//  Revision : 1.0 - initial release
// ============================================================================
module memory_reader
    import memory_pkg::*;
#(
    parameter int DATA_W = memory_pkg::DATA_W,
    parameter int ADDR_W = memory_pkg::ADDR_W,
    parameter int DEPTH  = memory_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    output logic [ADDR_W-1:0]        readAddress1,
    output logic [ADDR_W-1:0]        readAddress2,
    input  logic [DATA_W-1:0]        readData1,
    input  logic [DATA_W-1:0]        readData2,
    output logic                     busy,
    output logic                     done,
`ifdef MEMORY_READER_MAX_EN
    output logic [DATA_W-1:0]        max_val,
`endif
    output logic [DATA_W+ADDR_W-1:0] sum
);

    localparam int c_SUM_W  = DATA_W + ADDR_W;
    // The pair index only needs to count DEPTH/2 pairs; the address LSB
    // selects the even/odd word of the pair.
    localparam int c_PAIR_W = ADDR_W - 1;
    localparam logic [c_PAIR_W-1:0] c_LAST_PAIR = c_PAIR_W'(DEPTH / 2 - 1);

    reader_state_t       r_state;
    reader_state_t       w_state_next;
    logic [c_PAIR_W-1:0] r_pair_idx;
    logic [c_PAIR_W-1:0] w_pair_idx_next;
    logic                w_clear;
    logic                w_enable;

    // State and pair index registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_pair_idx <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pair_idx <= w_pair_idx_next;
        end
    end

    // Next-state, pair index sequencing and accumulator controls.
    always_comb begin
        w_state_next    = r_state;
        w_pair_idx_next = r_pair_idx;
        w_clear         = 1'b0;
        w_enable        = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        case (r_state)
            IDLE: begin
                w_pair_idx_next = '0;
                if (start) begin
                    w_state_next = SCAN;
                    w_clear      = 1'b1;
                end
            end
            SCAN: begin
                busy     = 1'b1;
                w_enable = 1'b1;
                if (r_pair_idx == c_LAST_PAIR) begin
                    w_state_next    = DONE;
                    w_pair_idx_next = '0;
                end else begin
                    w_pair_idx_next = r_pair_idx + c_PAIR_W'(1);
                end
            end
            DONE: begin
                done            = 1'b1;
                w_state_next    = IDLE;
                w_pair_idx_next = '0;
            end
            default: begin
                w_state_next    = IDLE;
                w_pair_idx_next = '0;
            end
        endcase
    end

    // Addresses come straight from the registered pair index, so they read
    // (0,1) whenever the reader is not scanning.
    assign readAddress1 = {r_pair_idx, 1'b0};
    assign readAddress2 = {r_pair_idx, 1'b1};

    pair_accumulator #(
        .DATA_W (DATA_W),
        .SUM_W  (c_SUM_W)
    ) u_pair_accumulator (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_clear),
        .i_enable  (w_enable),
        .i_data1   (readData1),
        .i_data2   (readData2),
`ifdef MEMORY_READER_MAX_EN
        .o_max_val (max_val),
`endif
        .o_sum     (sum)
    );

endmodule : memory_reader
`default_nettype wire

// File: tb/tb_memory_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_reader
//  Purpose  : Self-checking bench for memory_reader with a behavioural memory
//             and a queue-based scoreboard.
//  Options  : MEMORY_READER_MAX_EN also checks max_val.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_memory_reader;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DP = 16;
    localparam int NPAIR = DP / 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] readAddress1, readAddress2;
    logic [DW-1:0] readData1, readData2;
    logic          busy, done;
    logic [DW+AW-1:0] sum;
`ifdef MEMORY_READER_MAX_EN
    logic [DW-1:0] max_val;
`endif

    logic [DW-1:0] ram [DP];

    assign readData1 = ram[readAddress1];
    assign readData2 = ram[readAddress2];

    memory_reader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .readAddress1 (readAddress1),
        .readAddress2 (readAddress2),
        .readData1    (readData1),
        .readData2    (readData2),
        .busy         (busy),
        .done         (done),
`ifdef MEMORY_READER_MAX_EN
        .max_val      (max_val),
`endif
        .sum          (sum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int sum;
        int mx;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   last_sum = 0;

    function automatic void check(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endfunction

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_sum", int'(sum), e.sum);
                check("done_cycle", cyc, e.cyc);
`ifdef MEMORY_READER_MAX_EN
                check("done_max", int'(max_val), e.mx);
`endif
            end
        end
    end

    // Reference model: plain sum and maximum over the whole memory.
    function automatic exp_t model(int start_cyc);
        exp_t e;
        e.sum = 0;
        e.mx  = 0;
        for (int i = 0; i < DP; i++) begin
            e.sum += int'(ram[i]);
            if (int'(ram[i]) > e.mx) e.mx = int'(ram[i]);
        end
        e.cyc = start_cyc + 1 + NPAIR;
        return e;
    endfunction

    // mode 0: plain scan, 1: extra start pulses mid-scan and in DONE,
    // 2: reset asserted in the 4th scan cycle.
    task automatic run_scan(input int mode, input int gap);
        exp_t e;
        int   t;
        repeat (gap) @(negedge clk);
        e = model(cyc);
        sb.push_back(e);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < NPAIR; i++) begin
            @(negedge clk);
            check("scan_busy", int'(busy), 1);
            check("scan_addr1", int'(readAddress1), 2 * i);
            check("scan_addr2", int'(readAddress2), 2 * i + 1);
            if (mode == 1 && i == 2) start = 1'b1;
            if (mode == 1 && i == 3) start = 1'b0;
            if (mode == 2 && i == 3) begin
                reset_n = 1'b0;
                #1;
                check("abort_busy", int'(busy), 0);
                check("abort_done", int'(done), 0);
                check("abort_sum", int'(sum), 0);
                check("abort_addr1", int'(readAddress1), 0);
                check("abort_addr2", int'(readAddress2), 1);
                void'(sb.pop_back());
                @(negedge clk);
                check("abort_no_done", int'(done), 0);
                reset_n = 1'b1;
                return;
            end
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < 20);
        check("done_seen", int'(done), 1);
        check("done_busy_low", int'(busy), 0);
        last_sum = e.sum;
        if (mode == 1) begin
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (12) @(negedge clk);
            check("ignored_busy", int'(busy), 0);
            check("ignored_sum_hold", int'(sum), e.sum);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        for (int i = 0; i < DP; i++) ram[i] = DW'(i);
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_addr1", int'(readAddress1), 0);
        check("rst_addr2", int'(readAddress2), 1);
        reset_n = 1'b1;

        // Ascending contents.
        run_scan(0, 2);
        repeat (3) @(negedge clk);
        check("hold_sum_120", int'(sum), 120);
        check("idle_busy", int'(busy), 0);

        // All ones: largest possible sum, no wrap.
        for (int i = 0; i < DP; i++) ram[i] = 8'hFF;
        run_scan(0, 2);
        check("full_sum", last_sum, 4080);

        // Ignored start pulses.
        for (int i = 0; i < DP; i++) ram[i] = DW'(i);
        run_scan(1, 2);

        // Abort by reset, then a fresh scan.
        run_scan(2, 2);
        for (int i = 0; i < DP; i++) ram[i] = 8'd2;
        run_scan(0, 2);
        check("after_abort_sum", int'(sum), 32);

        // Back-to-back scans with contents changed in between.
        for (int i = 0; i < DP; i++) ram[i] = DW'(i);
        run_scan(0, 2);
        @(posedge clk);
        #1;
        for (int i = 0; i < DP; i++) ram[i] = DW'(15 - i);
        run_scan(0, 0);
        check("b2b_sum", int'(sum), 120);

        // Single large word among small ones.
        for (int i = 0; i < DP; i++) ram[i] = 8'h10;
        ram[7] = 8'hC3;
        run_scan(0, 2);
        check("peak_sum", int'(sum), 435);
`ifdef MEMORY_READER_MAX_EN
        check("peak_max", int'(max_val), 8'hC3);
`endif

        // Random contents and idle gaps.
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < DP; i++) ram[i] = DW'($urandom);
            run_scan(0, int'($urandom_range(1, 4)));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_memory_reader
`default_nettype wire
